// File: rtl/mem_access_stage.sv
// mem_access_stage -- MIPS-32 memory-access stage: word load/store over a req/ack bus,
// with pipeline stall, misalignment and bus-timeout detection.  Rev 1.0
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        BranchM,
  input  logic        zeroM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] readdataM,
  output logic        RegWriteQ,
  output logic        PCSrcM,
  output logic        stallM,
  output logic        addr_errM,
  output logic        bus_errM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      rdata_q, rdata_nxt;
  logic             bus_err, bus_err_nxt;
  logic             memop, misal;

  assign memop = MemWriteM | MemtoRegM;
  assign misal = memop & (aluoutM[1:0] != 2'b00);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rdata_nxt   = rdata_q;
    bus_err_nxt = bus_err;
    case (state)
      IDLE: begin
        if (memop && !misal) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        // An ack in the timeout cycle still counts as a successful access.
        if (dmem_ack) begin
          state_nxt = DONE;
          if (!MemWriteM) rdata_nxt = dmem_rdata;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = DONE;
          bus_err_nxt = 1'b1;
          rdata_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        bus_err_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
      bus_err <= bus_err_nxt;
    end
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = {aluoutM[31:2], 2'b00};
  assign dmem_wdata = writedataM;
  assign readdataM  = rdata_q;

  // Gated by reset so the stall request drops the instant reset is asserted.
  assign stallM    = reset & (((state == IDLE) & memop & ~misal) | dmem_req);
  assign addr_errM = misal;
  assign bus_errM  = bus_err;
  assign RegWriteQ = RegWriteM & ~misal & ~bus_err;
  assign PCSrcM    = BranchM & zeroM;

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (M) stage of the 5-stage MIPS-32 pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its M-side outputs.
- Runs word loads and stores on a data-memory bus with a req/ack handshake.
- Raises stallM to freeze the upstream stages while an access is outstanding.
- Detects misaligned addresses and bus timeouts.
- Produces readdataM, a qualified RegWrite and PCSrcM for the MEM/WB register and the fetch logic.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ without dmem_ack before a bus error (range 1..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- RegWriteM  input  1  register write enable from EX/MEM
- MemtoRegM  input  1  load indicator from EX/MEM
- MemWriteM  input  1  store indicator from EX/MEM
- BranchM  input  1  branch indicator from EX/MEM
- zeroM  input  1  ALU zero flag from EX/MEM
- aluoutM  input  32  effective address or ALU result
- writedataM  input  32  store data
- dmem_rdata  input  32  read data from data memory
- dmem_ack  input  1  memory completion strobe, valid only in REQ
- dmem_req  output  1  access request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  word address
- dmem_wdata  output  32  write data
- readdataM  output  32  captured load data
- RegWriteQ  output  1  RegWriteM qualified by errors
- PCSrcM  output  1  branch taken
- stallM  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
- addr_errM  output  1  misaligned access in current M instruction
- bus_errM  output  1  access timed out

Behaviour:
- Memory op: memop = MemWriteM | MemtoRegM. If both are 1, the op is a store (MemWriteM has priority).
- Misaligned: misal = memop & (aluoutM[1:0] != 0).
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE transitions:
  - memop & ~misal -> REQ.
  - Otherwise stay in IDLE.
- REQ transitions:
  - dmem_ack -> DONE; readdataM <= dmem_rdata on a load, unchanged on a store.
  - No ack and cnt == TIMEOUT-1 -> DONE; bus_err flag <= 1; readdataM <= 0.
  - Otherwise cnt <= cnt+1 and stay in REQ.
- DONE -> IDLE unconditionally. bus_err flag clears on this exit.
- Counter: cnt is cleared on entry to REQ and saturates; it never wraps.
- stallM = (IDLE & memop & ~misal) | REQ. stallM is 0 in DONE, so the pipeline advances at the DONE edge.
- Access latency: with zero-wait ack (ack in the first REQ cycle), stallM is high for 2 cycles (IDLE, REQ), then DONE follows.
- Bus outputs:
  - dmem_req = (state == REQ).
  - dmem_we = REQ & MemWriteM.
  - dmem_addr = {aluoutM[31:2], 2'b00}.
  - dmem_wdata = writedataM.
  - EX/MEM inputs are stable throughout REQ because the stage is stalled.
- Misaligned op: no bus request and no stall. addr_errM = misal (combinational); RegWriteQ forced to 0.
- bus_errM is registered and is high only in the DONE cycle after a timeout.
- RegWriteQ = RegWriteM & ~addr_errM & ~bus_errM.
- PCSrcM = BranchM & zeroM (combinational, independent of the FSM).
- dmem_ack outside REQ is ignored.
- An ack arriving in the same cycle as the timeout is taken as success (ack wins).
- Async reset, including mid-access: all of the following take effect immediately, with no clock edge needed:
  - state=IDLE, cnt=0, readdataM=0, bus_err=0;
  - dmem_req=0, stallM=0.
  - A store dropped by reset mid-access is not retried.
- Outputs after reset, with no memop presented: readdataM=0, dmem_req=0, dmem_we=0, stallM=0, addr_errM=0, bus_errM=0.
- A non-memory instruction passes through M with no state change and no stall.

Test Plan:
- Load, zero-wait: MemtoRegM=1, aluoutM=0x100, ack in the first REQ cycle with dmem_rdata=0xCAFEF00D -> dmem_req high 1 cycle with dmem_addr=0x100 and dmem_we=0; stallM high 2 cycles; readdataM=0xCAFEF00D in DONE; RegWriteQ=1.
- Store, 3-wait: MemWriteM=1, aluoutM=0x204, writedataM=0x12345678, ack on the 4th REQ cycle -> dmem_we=1 and dmem_wdata=0x12345678 held for 4 cycles; stallM high 5 cycles; then DONE and IDLE.
- Misaligned: MemtoRegM=1, aluoutM=0x102, RegWriteM=1 -> dmem_req stays 0; stallM=0; addr_errM=1; RegWriteQ=0.
- Timeout: TIMEOUT=4, load with no ack -> exactly 4 REQ cycles; then DONE with bus_errM=1, readdataM=0, RegWriteQ=0; next cycle bus_errM=0 and state IDLE.
- Reset mid-access: assert reset low in the 2nd REQ cycle -> dmem_req and stallM drop in the same cycle; readdataM=0; after release, an ALU-only instruction gives stallM=0.
- Branch: BranchM=1, zeroM=1 -> PCSrcM=1; with zeroM=0 -> PCSrcM=0; a late ack in IDLE has no effect.
